// File: rtl/matrix_calc_dispatcher_pkg.sv
// matrix_calc_dispatcher_pkg
// Dispatcher state encoding, error codes and the calc-type to unit-select
// helper used by matrix_calc_dispatcher.
package matrix_calc_dispatcher_pkg;

    import matrix_op_selector_pkg::*;

    localparam int NUM_UNITS = 5;

    // Highest calc type that has a compute unit behind it.
    localparam logic [2:0] CALC_LAST = CALC_CONV;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ACQUIRE,
        ST_LAUNCH,
        ST_RUN,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BAD_TYPE = 2'd1,
        ERR_UNIT     = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_t;

    // One-hot unit select for a calc type; out-of-range types select nothing.
    function automatic logic [NUM_UNITS-1:0] unit_select(input logic [2:0] calc);
        logic [NUM_UNITS-1:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (calc == 3'(i)) begin
                sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/matrix_op_selector_pkg.sv
// matrix_op_selector_pkg
// Types shared with the operation selector FSM. The calc type value doubles
// as the index of the compute unit that implements it, so the dispatcher can
// address unit start/done/err vectors directly by calc type.
package matrix_op_selector_pkg;

    typedef enum logic [2:0] {
        CALC_TRANSPOSE  = 3'd0,
        CALC_ADD        = 3'd1,
        CALC_MUL        = 3'd2,
        CALC_SCALAR_MUL = 3'd3,
        CALC_CONV       = 3'd4
    } calc_type_t;

endpackage

// File: rtl/matrix_calc_dispatcher_timeout.sv
// op_timeout_counter
// Watchdog counter for the bus-holding phase of a calculation.
//   clk, rst  : clock, async active-high reset
//   clear     : restart the count from zero (wins over enable)
//   enable    : count this cycle
//   expired   : this enabled cycle brings the count to TIMEOUT_CYCLES-1
// Expects TIMEOUT_CYCLES >= 2.
module op_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Flag the cycle whose increment reaches the limit, so the owner can
    // abort on that same edge instead of one cycle later.
    assign expired = enable && (count == PRE_LAST);

endmodule

// File: rtl/matrix_calc_dispatcher.sv
// matrix_calc_dispatcher
// Runs one matrix calculation per accepted request: validates the calc type,
// acquires the shared storage bus, pulses the matching unit's start, waits for
// its done/err (bounded by a timeout), then releases the bus and reports.
// Ports:
//   clk, rst                  : clock, async active-high reset
//   req_valid/req_ready       : request handshake (ready only in IDLE)
//   req_calc/id_a/id_b/scalar : request payload
//   bus_req/bus_gnt           : storage bus arbitration
//   unit_start                : one-hot start pulse, bit = calc type
//   unit_id_a/id_b/scalar     : operands latched at acceptance
//   unit_done/unit_err        : per-unit completion flags
//   busy, cur_calc            : status
//   done/error/err_code       : completion pulses and sticky error code
// All outputs are registered.
module matrix_calc_dispatcher
    import matrix_op_selector_pkg::*;
    import matrix_calc_dispatcher_pkg::*;
#(
    parameter int ID_W           = 3,
    parameter int SCALAR_W       = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_calc,
    input  logic [ID_W-1:0]      req_id_a,
    input  logic [ID_W-1:0]      req_id_b,
    input  logic [SCALAR_W-1:0]  req_scalar,
    output logic                 bus_req,
    input  logic                 bus_gnt,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic [ID_W-1:0]      unit_id_a,
    output logic [ID_W-1:0]      unit_id_b,
    output logic [SCALAR_W-1:0]  unit_scalar,
    input  logic [NUM_UNITS-1:0] unit_done,
    input  logic [NUM_UNITS-1:0] unit_err,
    output logic                 busy,
    output logic [2:0]           cur_calc,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code
);

    state_t                 state;
    state_t                 state_next;
    err_code_t              err_next;
    logic [NUM_UNITS-1:0]   own_sel;
    logic                   own_done;
    logic                   own_err;
    logic                   tmo_clear;
    logic                   tmo_enable;
    logic                   tmo_expired;

    // Only the launched unit's flags matter; other units may be busy with
    // unrelated work and their flags are ignored.
    assign own_sel  = unit_select(cur_calc);
    assign own_done = |(unit_done & own_sel);
    assign own_err  = |(unit_err & own_sel);

    assign tmo_clear  = (state == ST_CHECK);
    assign tmo_enable = (state == ST_ACQUIRE) || (state == ST_RUN);

    op_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // Next-state decode. Timeout beats unit flags, and err beats done.
    always_comb begin
        state_next = state;
        err_next   = ERR_NONE;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (cur_calc > CALC_LAST) begin
                    state_next = ST_ERROR;
                    err_next   = ERR_BAD_TYPE;
                end else begin
                    state_next = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                if (tmo_expired) begin
                    state_next = ST_ERROR;
                    err_next   = ERR_TIMEOUT;
                end else if (bus_gnt) begin
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (tmo_expired) begin
                    state_next = ST_ERROR;
                    err_next   = ERR_TIMEOUT;
                end else if (own_err) begin
                    state_next = ST_ERROR;
                    err_next   = ERR_UNIT;
                end else if (own_done) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_ERROR: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register plus outputs decoded from the next state, so every
    // output is a flop that already reflects the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            bus_req     <= 1'b0;
            unit_start  <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
            cur_calc    <= '0;
            unit_id_a   <= '0;
            unit_id_b   <= '0;
            unit_scalar <= '0;
        end else begin
            state      <= state_next;
            req_ready  <= (state_next == ST_IDLE);
            busy       <= (state_next != ST_IDLE);
            bus_req    <= (state_next == ST_ACQUIRE) || (state_next == ST_LAUNCH) ||
                          (state_next == ST_RUN);
            unit_start <= (state_next == ST_LAUNCH) ? own_sel : '0;
            done       <= (state_next == ST_DONE);
            error      <= (state_next == ST_ERROR);

            if ((state == ST_IDLE) && req_valid) begin
                cur_calc    <= req_calc;
                unit_id_a   <= req_id_a;
                unit_id_b   <= req_id_b;
                unit_scalar <= req_scalar;
                err_code    <= ERR_NONE;
            end else if (state_next == ST_ERROR) begin
                err_code    <= err_next;
            end
        end
    end

endmodule

// File: tb/tb_matrix_calc_dispatcher.sv
// tb_matrix_calc_dispatcher
// Directed bench for matrix_calc_dispatcher. Each request is described by its
// grant delay and unit response; a timeline model derives, from those alone,
// which relative cycle every output must change in. One compare process
// checks all outputs every cycle against that timeline and, at the end of
// each request, against hand-computed literals.
module tb_matrix_calc_dispatcher;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_calc = '0;
    logic [2:0]  req_id_a = '0;
    logic [2:0]  req_id_b = '0;
    logic [31:0] req_scalar = '0;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic [4:0]  unit_start;
    logic [2:0]  unit_id_a;
    logic [2:0]  unit_id_b;
    logic [31:0] unit_scalar;
    logic [4:0]  unit_done = '0;
    logic [4:0]  unit_err = '0;
    logic        busy;
    logic [2:0]  cur_calc;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    matrix_calc_dispatcher #(
        .ID_W(3),
        .SCALAR_W(32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_calc(req_calc),
        .req_id_a(req_id_a), .req_id_b(req_id_b), .req_scalar(req_scalar),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .unit_start(unit_start), .unit_id_a(unit_id_a), .unit_id_b(unit_id_b),
        .unit_scalar(unit_scalar), .unit_done(unit_done), .unit_err(unit_err),
        .busy(busy), .cur_calc(cur_calc), .done(done), .error(error),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Timeline model of the request in flight (relative cycle 1 = CHECK).
    bit          m_active = 1'b0;
    int          m_acc = 0;
    int          m_end = 0;
    int          m_launch = 0;
    bit          m_buspath = 1'b0;
    bit          m_launched = 1'b0;
    bit          m_succ = 1'b0;
    logic [1:0]  m_code = '0;
    logic [2:0]  m_calc = '0;
    logic [2:0]  m_ida = '0;
    logic [2:0]  m_idb = '0;
    logic [31:0] m_sc = '0;
    bit          m_lit_on = 1'b0;
    int          l_start_cnt = 0;
    logic [4:0]  l_start_val = '0;
    int          l_pre = 0;
    int          l_done = 0;
    int          l_err = 0;
    int          l_end = 0;
    logic [1:0]  l_code = '0;

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // Offer one request, then drive grant and unit flags cycle by cycle from
    // the request description until the dispatcher is back in IDLE.
    task automatic applyStimulus(
        input logic [2:0] calc, input logic [2:0] ida, input logic [2:0] idb,
        input logic [31:0] sc, input int g, input int r,
        input logic [4:0] dv, input logic [4:0] ev,
        input logic [4:0] nl, input logic [4:0] nr, input bit drop,
        input int abort_rel, input bit lit_on,
        input int ls_cnt, input logic [4:0] ls_val, input int lp,
        input int ld, input int le, input int lend, input logic [1:0] lcode);
        int  rel;
        int  launch_rel;
        bit  aborted;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_calc   = calc;
        req_id_a   = ida;
        req_id_b   = idb;
        req_scalar = sc;
        @(posedge clk); #1;
        launch_rel = 2 + g;
        m_calc = calc; m_ida = ida; m_idb = idb; m_sc = sc;
        m_launch = launch_rel;
        if (calc > 3'd4) begin
            m_end = 2; m_code = 2'd1; m_succ = 1'b0;
            m_buspath = 1'b0; m_launched = 1'b0;
        end else if (g >= T - 1) begin
            m_end = T + 1; m_code = 2'd3; m_succ = 1'b0;
            m_buspath = 1'b1; m_launched = 1'b0;
        end else begin
            m_buspath = 1'b1; m_launched = 1'b1;
            if ((dv[calc] || ev[calc]) && (g + r <= T - 2)) begin
                m_end  = launch_rel + r + 1;
                m_succ = !ev[calc];
                m_code = ev[calc] ? 2'd2 : 2'd0;
            end else begin
                m_end = T + 2; m_code = 2'd3; m_succ = 1'b0;
            end
        end
        m_lit_on = lit_on;
        l_start_cnt = ls_cnt; l_start_val = ls_val; l_pre = lp;
        l_done = ld; l_err = le; l_end = lend; l_code = lcode;
        m_acc = cyc;
        m_active = 1'b1;
        req_valid  = 1'b0;
        req_calc   = 3'($urandom);
        req_id_a   = 3'($urandom);
        req_id_b   = 3'($urandom);
        req_scalar = $urandom;
        rel = 1;
        aborted = 1'b0;
        while (!aborted && rel <= m_end + 1) begin
            bus_gnt   = (rel >= g + 1) && (!drop || rel <= g + 2);
            unit_done = '0;
            unit_err  = '0;
            if (rel == launch_rel) unit_done = nl;
            if (rel > launch_rel && rel < launch_rel + r) unit_done = nr;
            if (rel == launch_rel + r) begin
                unit_done = dv;
                unit_err  = ev;
            end
            if (rel == abort_rel) begin
                #2;
                rst = 1'b1;
                m_active = 1'b0;
                repeat (2) @(posedge clk);
                #3;
                rst = 1'b0;
                aborted = 1'b1;
            end else begin
                @(posedge clk); #1;
                rel = cyc - m_acc + 1;
            end
        end
        bus_gnt   = 1'b0;
        unit_done = '0;
        unit_err  = '0;
    endtask

    // Single compare process: every cycle, plus right after reset rises.
    initial begin : compare
        int n;
        int last_acc;
        int st_cnt, pre, dcnt, ecnt, end_seen;
        logic [4:0] st_val;
        bit fin;
        logic e_rdy, e_busy, e_breq, e_done, e_err;
        logic [4:0] e_start;
        logic [1:0] e_code;
        logic [2:0] e_calc, e_ida, e_idb;
        logic [31:0] e_sc;
        last_acc = -1;
        st_cnt = 0; pre = 0; dcnt = 0; ecnt = 0; end_seen = 0; st_val = '0; fin = 1'b0;
        n = 0;
        forever begin
            @(negedge clk or posedge rst);
            #1;
            if (rst || !m_active) begin
                e_rdy = 1'b1; e_busy = 1'b0; e_breq = 1'b0; e_done = 1'b0; e_err = 1'b0;
                e_start = '0; e_code = '0; e_calc = '0; e_ida = '0; e_idb = '0; e_sc = '0;
            end else begin
                n      = cyc - m_acc + 1;
                e_busy = (n >= 1) && (n <= m_end);
                e_rdy  = !e_busy;
                e_breq = m_buspath && (n >= 2) && (n <= m_end - 1);
                e_start = (m_launched && n == m_launch) ? (5'd1 << m_calc) : 5'd0;
                e_done = (n == m_end) && m_succ;
                e_err  = (n == m_end) && !m_succ;
                e_code = (n >= m_end) ? m_code : 2'd0;
                e_calc = m_calc; e_ida = m_ida; e_idb = m_idb; e_sc = m_sc;
            end
            checkOutput("req_ready", 64'(req_ready), 64'(e_rdy));
            checkOutput("busy", 64'(busy), 64'(e_busy));
            checkOutput("bus_req", 64'(bus_req), 64'(e_breq));
            checkOutput("unit_start", 64'(unit_start), 64'(e_start));
            checkOutput("done", 64'(done), 64'(e_done));
            checkOutput("error", 64'(error), 64'(e_err));
            checkOutput("err_code", 64'(err_code), 64'(e_code));
            checkOutput("cur_calc", 64'(cur_calc), 64'(e_calc));
            checkOutput("unit_id_a", 64'(unit_id_a), 64'(e_ida));
            checkOutput("unit_id_b", 64'(unit_id_b), 64'(e_idb));
            checkOutput("unit_scalar", 64'(unit_scalar), 64'(e_sc));
            if (m_active && !rst) begin
                if (m_acc != last_acc) begin
                    last_acc = m_acc;
                    st_cnt = 0; pre = 0; dcnt = 0; ecnt = 0; end_seen = 0;
                    st_val = '0; fin = 1'b0;
                end
                if (bus_req && unit_start == 5'd0 && st_cnt == 0) pre++;
                if (unit_start != 5'd0) begin
                    st_cnt++;
                    st_val = unit_start;
                end
                if (done) begin
                    dcnt++;
                    end_seen = n;
                end
                if (error) begin
                    ecnt++;
                    end_seen = n;
                end
                if (!fin && m_lit_on && n == m_end + 1) begin
                    fin = 1'b1;
                    checkOutput("lit_model_end", 64'(m_end), 64'(l_end));
                    checkOutput("lit_start_pulses", 64'(st_cnt), 64'(l_start_cnt));
                    checkOutput("lit_start_value", 64'(st_val), 64'(l_start_val));
                    checkOutput("lit_bus_req_before_launch", 64'(pre), 64'(l_pre));
                    checkOutput("lit_done_pulses", 64'(dcnt), 64'(l_done));
                    checkOutput("lit_error_pulses", 64'(ecnt), 64'(l_err));
                    checkOutput("lit_end_cycle", 64'(end_seen), 64'(l_end));
                    checkOutput("lit_err_code", 64'(err_code), 64'(l_code));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] start, TIMEOUT_CYCLES=%0d", T);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        // ADD ids 2/5, done 3 cycles after start
        applyStimulus(3'd1, 3'd2, 3'd5, 32'hDEADBEEF, 1, 3, 5'b00010, 5'b0, 5'b0, 5'b0, 1'b0,
                      0, 1'b1, 1, 5'b00010, 1, 1, 0, 7, 2'd0);
        // Unsupported calc type 6
        applyStimulus(3'd6, 3'd1, 3'd1, 32'h12345678, 1, 99, 5'b0, 5'b0, 5'b0, 5'b0, 1'b0,
                      0, 1'b1, 0, 5'b0, 0, 0, 1, 2, 2'd1);
        // SCALAR_MUL, grant after 10 ACQUIRE cycles, grant dropped during RUN
        applyStimulus(3'd3, 3'd6, 3'd3, 32'h3F800000, 10, 2, 5'b01000, 5'b0, 5'b0, 5'b0, 1'b1,
                      0, 1'b1, 1, 5'b01000, 10, 1, 0, 15, 2'd0);
        // MUL, done+err together; own done at LAUNCH and unit 0 done in RUN ignored
        applyStimulus(3'd2, 3'd1, 3'd7, 32'h0, 1, 2, 5'b00100, 5'b00100, 5'b00100, 5'b00001, 1'b0,
                      0, 1'b1, 1, 5'b00100, 1, 0, 1, 6, 2'd2);
        // CONV never finishes: timeout 16 cycles after entering ACQUIRE
        applyStimulus(3'd4, 3'd3, 3'd0, 32'h0, 1, 99, 5'b0, 5'b0, 5'b0, 5'b0, 1'b0,
                      0, 1'b1, 1, 5'b10000, 1, 0, 1, 18, 2'd3);
        // ADD, grant never arrives: timeout in ACQUIRE
        applyStimulus(3'd1, 3'd7, 3'd7, 32'h0, 20, 99, 5'b0, 5'b0, 5'b0, 5'b0, 1'b0,
                      0, 1'b1, 0, 5'b0, 15, 0, 1, 17, 2'd3);
        // TRANSPOSE, done on the last cycle before the timeout
        applyStimulus(3'd0, 3'd4, 3'd0, 32'h0, 1, 13, 5'b00001, 5'b0, 5'b0, 5'b0, 1'b0,
                      0, 1'b1, 1, 5'b00001, 1, 1, 0, 17, 2'd0);
        // TRANSPOSE, done in the same cycle as the timeout: timeout wins
        applyStimulus(3'd0, 3'd4, 3'd0, 32'h0, 1, 14, 5'b00001, 5'b0, 5'b0, 5'b0, 1'b0,
                      0, 1'b1, 1, 5'b00001, 1, 0, 1, 18, 2'd3);
        // CONV interrupted by reset in RUN
        applyStimulus(3'd4, 3'd2, 3'd6, 32'h0000CAFE, 1, 99, 5'b0, 5'b0, 5'b0, 5'b0, 1'b0,
                      6, 1'b0, 0, 5'b0, 0, 0, 0, 0, 2'd0);
        // MUL after reset completes normally
        applyStimulus(3'd2, 3'd5, 3'd2, 32'h0, 1, 1, 5'b00100, 5'b0, 5'b0, 5'b0, 1'b0,
                      0, 1'b1, 1, 5'b00100, 1, 1, 0, 5, 2'd0);
        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_calc_dispatcher.md
# matrix_calc_dispatcher

Sequences one matrix calculation after the operation selector has chosen a calc type, operand IDs and an optional scalar.
- Accepts one request per handshake and validates the calc type.
- Acquires the shared matrix-storage bus and launches the matching compute unit.
- Waits for that unit to finish, then releases the bus and reports done or error.
- Sits between the selector FSM and the compute units (transpose, add, mul, scalar-mul, conv).

## Interface
Parameters:
- ID_W, 3: matrix ID width
- SCALAR_W, 32: scalar operand width
- TIMEOUT_CYCLES, 1000000: max cycles spent in ACQUIRE+RUN before abort

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  async active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  high only in IDLE
- req_calc  in  3  calc_type_t
- req_id_a  in  ID_W  operand A
- req_id_b  in  ID_W  operand B; ignored for TRANSPOSE and SCALAR_MUL
- req_scalar  in  SCALAR_W  used by SCALAR_MUL only
- bus_req  out  1  storage bus request
- bus_gnt  in  1  storage bus grant
- unit_start  out  5  one-hot start pulse; bit index equals calc_type_t value
- unit_id_a, unit_id_b  out  ID_W  latched operand IDs
- unit_scalar  out  SCALAR_W  latched scalar
- unit_done  in  5  per-unit done
- unit_err  in  5  per-unit error
- busy  out  1  high outside IDLE
- cur_calc  out  3  latched calc type
- done  out  1  one-cycle success pulse
- error  out  1  one-cycle failure pulse
- err_code  out  2  0 none, 1 bad type, 2 unit error, 3 timeout

## Operation
FSM states: IDLE, CHECK, ACQUIRE, LAUNCH, RUN, DONE, ERROR.
- IDLE:
  - req_ready=1.
  - On req_valid, latch calc/IDs/scalar into cur_calc/unit_* and go to CHECK.
  - err_code clears to 0 on acceptance.
- CHECK (1 cycle):
  - cur_calc > 4 → ERROR with code 1.
  - Otherwise → ACQUIRE; clear timeout counter.
- ACQUIRE:
  - bus_req=1.
  - bus_gnt=1 → LAUNCH.
- LAUNCH (1 cycle):
  - unit_start[cur_calc]=1, all other bits 0; bus_req stays 1.
  - → RUN.
- RUN:
  - bus_req=1; only bit cur_calc of unit_done/unit_err is sampled.
  - unit_err bit → ERROR with code 2.
  - unit_done bit → DONE.
  - Both bits in the same cycle → err wins.
- Timeout: the counter increments every cycle in ACQUIRE and RUN. Reaching TIMEOUT_CYCLES-1 → ERROR with code 3. Timeout has priority over done/err in the same cycle.
- DONE: done=1, bus_req=0 → IDLE.
- ERROR:
  - error=1, bus_req=0; err_code is loaded on entry.
  - err_code holds until the next accepted request.
  - → IDLE.
- Error and done pulses never overlap.
- unit_id_a/unit_id_b/unit_scalar/cur_calc hold their values from acceptance until the next acceptance.

## Timing
- Reset values: req_ready=1, bus_req=0, unit_start=0, busy=0, done=0, error=0, err_code=0, cur_calc=0, unit_id_a=0, unit_id_b=0, unit_scalar=0, counter=0, state IDLE.
- Cycle numbering, with acceptance at edge 0 and bus_gnt already high:
  - CHECK at cycle 1, ACQUIRE at cycle 2.
  - LAUNCH at cycle 3: unit_start pulse.
  - RUN from cycle 4.
- unit_done sampled in RUN cycle k → done=1 at cycle k+1 and bus_req low at cycle k+1 → req_ready=1 at cycle k+2.
- Units must not raise done/err in the LAUNCH cycle; such a raise is ignored.
- Bad-type path: accept at 0, CHECK at 1, error pulse at 2, IDLE at 3; bus_req never asserted.
- bus_gnt dropping during RUN is ignored; the dispatcher holds bus_req until DONE/ERROR.
- Reset mid-operation asynchronously forces all outputs to their reset values, including dropping bus_req.
- All outputs are registered.

## Structure
- calc_type_t comes from matrix_op_selector_pkg.
- Add to a new matrix_calc_dispatcher_pkg:
  - dispatcher state_t enum
  - err_code_t enum {ERR_NONE, ERR_BAD_TYPE, ERR_UNIT, ERR_TIMEOUT}
  - NUM_UNITS=5
- One sub-module: op_timeout_counter, holding the clear/enable/expired counter parameterized by TIMEOUT_CYCLES and using $clog2 width.

## Test plan
- ADD, ids 2/5, gnt high, unit_done[1] 3 cycles after start → unit_start=5'b00010 for exactly 1 cycle, unit_id_a=2, unit_id_b=5, then done pulse, err_code=0.
- req_calc=6 → error at cycle 2, err_code=1, bus_req never high, unit_start stays 0.
- SCALAR_MUL, scalar=0x3F800000, gnt delayed 10 cycles → bus_req high 10 cycles before LAUNCH, unit_scalar=0x3F800000, start on bit 3.
- MUL, unit_done[2] and unit_err[2] in the same cycle → error pulse, err_code=2, no done pulse; unit_done[0] during RUN is ignored.
- TIMEOUT_CYCLES=16, CONV with unit never done → error with err_code=3 exactly 16 cycles after entering ACQUIRE, bus_req low.
- rst asserted mid-RUN → all outputs reset immediately; a new request afterwards completes normally.
